// File: rtl/ogege_video_pkg.sv
// Shared video constants, mode encoding and per-mode fetch geometry for the
// frame buffer scan-out path.
package ogege_video_pkg;

   localparam int unsigned H_PIXELS  = 640;
   localparam int unsigned V_LINES   = 480;
   localparam int unsigned LAST_LINE = V_LINES - 1;

   typedef enum logic [1:0] {
      Mode320x240x8 = 2'd0,
      Mode320x480x4 = 2'd1,
      Mode640x240x4 = 2'd2,
      Mode640x480x2 = 2'd3
   } video_mode_e;

   typedef enum logic [1:0] {
      StIdle,
      StFetch,
      StDrain
   } fetch_state_e;

   function automatic logic [5:0] words_per_row(input video_mode_e m);
      logic [5:0] n;
      unique case (m)
         Mode320x240x8: n = 6'd32;
         Mode320x480x4: n = 6'd16;
         Mode640x240x4: n = 6'd32;
         Mode640x480x2: n = 6'd16;
      endcase
      return n;
   endfunction

   // Display pixels covered by one buffer word, after horizontal doubling.
   function automatic logic [5:0] pix_per_word(input video_mode_e m);
      logic [5:0] n;
      unique case (m)
         Mode320x240x8: n = 6'd20;
         Mode320x480x4: n = 6'd40;
         Mode640x240x4: n = 6'd20;
         Mode640x480x2: n = 6'd40;
      endcase
      return n;
   endfunction

   function automatic logic [3:0] bits_per_pixel(input video_mode_e m);
      logic [3:0] n;
      unique case (m)
         Mode320x240x8: n = 4'd8;
         Mode320x480x4: n = 4'd4;
         Mode640x240x4: n = 4'd4;
         Mode640x480x2: n = 4'd2;
      endcase
      return n;
   endfunction

   function automatic logic h_double(input video_mode_e m);
      return (m == Mode320x240x8) || (m == Mode320x480x4);
   endfunction

   function automatic logic v_double(input video_mode_e m);
      return (m == Mode320x240x8) || (m == Mode640x240x4);
   endfunction

endpackage

// File: rtl/scan_word_fifo.sv
// Two-entry word buffer between the frame buffer read port and the pixel
// serialiser; flush has priority over push and pop.
module scan_word_fifo #(
   parameter int unsigned DATA_WIDTH = 80
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_flush,
   input  logic                  i_push,
   input  logic [DATA_WIDTH-1:0] i_push_data,
   input  logic                  i_pop,
   output logic [DATA_WIDTH-1:0] o_head,
   output logic [1:0]            o_count
);

   logic [DATA_WIDTH-1:0] r_mem [2];
   logic                  r_rd_ptr;
   logic                  r_wr_ptr;
   logic [1:0]            r_count;
   logic                  w_do_push;
   logic                  w_do_pop;

   // A push into a full buffer is legal when the head leaves in the same clk.
   always_comb begin
      w_do_pop  = i_pop && (r_count != 2'd0);
      w_do_push = i_push && ((r_count != 2'd2) || w_do_pop);
   end

   always_ff @(posedge i_clk) begin
      if (i_reset || i_flush) begin
         r_rd_ptr <= 1'b0;
         r_wr_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_do_push) r_wr_ptr <= !r_wr_ptr;
         if (w_do_pop)  r_rd_ptr <= !r_rd_ptr;
         r_count <= r_count + 2'(w_do_push) - 2'(w_do_pop);
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
   end

   assign o_head  = r_mem[r_rd_ptr];
   assign o_count = r_count;

endmodule

// File: rtl/frame_scanner.sv
// Scan-out engine: fetches one stored row per display line from the frame
// buffer and serialises it into palette indices on pix_en.
module frame_scanner
   import ogege_video_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 80,
   parameter int unsigned ADDR_WIDTH = 13
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [1:0]            mode,
   input  logic                  frame_start,
   input  logic                  line_start,
   input  logic                  pix_en,
   output logic [ADDR_WIDTH-1:0] rd_addr,
   input  logic [DATA_WIDTH-1:0] rd_data,
   output logic [7:0]            pix_index,
   output logic                  pix_valid,
   output logic                  underrun
);

   video_mode_e           r_mode;
   fetch_state_e          r_state;
   logic [8:0]            r_line;
   logic                  r_line_seen;
   logic [12:0]           r_row_base;
   logic [5:0]            r_word_idx;
   logic                  r_req;
   logic                  r_pend;
   logic [ADDR_WIDTH-1:0] r_rd_addr;
   logic [5:0]            r_pix_pos;
   logic [7:0]            r_pix_index;
   logic                  r_pix_valid;
   logic                  r_underrun;

   video_mode_e           w_mode_eff;
   logic                  w_seen_eff;
   logic [8:0]            w_line_eff;
   logic [8:0]            w_line_new;
   logic                  w_line_go;
   logic [12:0]           w_base;
   logic                  w_flush;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_serve;
   logic                  w_fifo_empty;
   logic                  w_can_issue;
   logic [1:0]            w_count;
   logic [2:0]            w_occupancy;
   logic [DATA_WIDTH-1:0] w_head;
   logic [5:0]            w_wpr;
   logic [5:0]            w_ppw;
   logic [5:0]            w_sub;
   logic [3:0]            w_bpp;
   logic [6:0]            w_shift;
   logic [DATA_WIDTH-1:0] w_shifted;
   logic [7:0]            w_top;
   logic [7:0]            w_pix;

   // frame_start takes effect before a coincident line_start, so the line
   // decision below works on the post-frame_start view of mode and line.
   always_comb begin
      w_mode_eff   = frame_start ? video_mode_e'(mode) : r_mode;
      w_seen_eff   = frame_start ? 1'b0 : r_line_seen;
      w_line_eff   = frame_start ? 9'd0 : r_line;
      w_line_new   = w_seen_eff ? w_line_eff + 9'd1 : w_line_eff;
      w_line_go    = line_start && !(w_seen_eff && (w_line_eff == 9'(LAST_LINE)));
      w_base       = v_double(w_mode_eff) ? {w_line_new[8:1], 5'd0} : {w_line_new, 4'd0};
      w_flush      = frame_start || w_line_go;
      w_push       = r_pend && !w_flush;
      w_fifo_empty = (w_count == 2'd0);
      w_occupancy  = 3'(w_count) + 3'(r_req) + 3'(r_pend);
      w_can_issue  = (r_state == StFetch) && (w_occupancy < 3'd2);
      w_wpr        = words_per_row(r_mode);
      w_ppw        = pix_per_word(r_mode);
      w_serve      = pix_en && !w_fifo_empty;
      w_pop        = w_serve && (r_pix_pos == w_ppw - 6'd1);
   end

   // Pixel select: first pixel sits in the most-significant bits of the word.
   always_comb begin
      w_bpp     = bits_per_pixel(r_mode);
      w_sub     = h_double(r_mode) ? (r_pix_pos >> 1) : r_pix_pos;
      w_shift   = 7'(w_sub) * 7'(w_bpp);
      w_shifted = w_head << w_shift;
      w_top     = w_shifted[DATA_WIDTH-1 -: 8];
      w_pix     = w_top;
      if (w_bpp == 4'd4) begin
         w_pix = {4'd0, w_top[7:4]};
      end else if (w_bpp == 4'd2) begin
         w_pix = {6'd0, w_top[7:6]};
      end
   end

   scan_word_fifo #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_fifo (
      .i_clk       (clk),
      .i_reset     (reset),
      .i_flush     (w_flush),
      .i_push      (w_push),
      .i_push_data (rd_data),
      .i_pop       (w_pop),
      .o_head      (w_head),
      .o_count     (w_count)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_mode      <= Mode320x240x8;
         r_state     <= StIdle;
         r_line      <= 9'd0;
         r_line_seen <= 1'b0;
         r_row_base  <= 13'd0;
         r_word_idx  <= 6'd0;
         r_req       <= 1'b0;
         r_pend      <= 1'b0;
         r_rd_addr   <= '0;
         r_pix_pos   <= 6'd0;
         r_pix_index <= 8'd0;
         r_pix_valid <= 1'b0;
         r_underrun  <= 1'b0;
      end else begin
         if (frame_start) begin
            r_mode      <= video_mode_e'(mode);
            r_line      <= 9'd0;
            r_line_seen <= 1'b0;
         end

         // A read issued before a flush must not land in the new line.
         r_pend <= r_req && !w_flush;
         r_req  <= 1'b0;

         if (w_line_go) begin
            r_line      <= w_line_new;
            r_line_seen <= 1'b1;
            r_row_base  <= w_base;
            r_rd_addr   <= ADDR_WIDTH'(w_base);
            r_req       <= 1'b1;
            r_word_idx  <= 6'd1;
            r_state     <= StFetch;
         end else if (frame_start) begin
            r_state <= StIdle;
         end else begin
            case (r_state)
               StFetch: begin
                  if (w_can_issue) begin
                     r_rd_addr  <= ADDR_WIDTH'(r_row_base + 13'(r_word_idx));
                     r_req      <= 1'b1;
                     r_word_idx <= r_word_idx + 6'd1;
                     if (r_word_idx == w_wpr - 6'd1) r_state <= StDrain;
                  end
               end
               StDrain: begin
                  if (w_fifo_empty && !r_req && !r_pend) r_state <= StIdle;
               end
               default: r_state <= StIdle;
            endcase
         end

         r_pix_valid <= pix_en;
         if (pix_en) r_pix_index <= w_serve ? w_pix : 8'd0;

         if (w_flush) begin
            r_pix_pos <= 6'd0;
         end else if (w_serve) begin
            r_pix_pos <= w_pop ? 6'd0 : r_pix_pos + 6'd1;
         end

         if (frame_start) begin
            r_underrun <= 1'b0;
         end else if (pix_en && w_fifo_empty) begin
            r_underrun <= 1'b1;
         end
      end
   end

   assign rd_addr   = r_rd_addr;
   assign pix_index = r_pix_index;
   assign pix_valid = r_pix_valid;
   assign underrun  = r_underrun;

endmodule

// File: tb/tb_frame_scanner.sv
// Randomised bench for frame_scanner: random frame buffer image, random pixel
// cadence, every displayed pixel compared against a raster-level model.
module tb_frame_scanner;

   localparam int DW     = 80;
   localparam int AW     = 13;
   localparam int NWORDS = 7680;

   logic          clk = 1'b0;
   logic          reset;
   logic [1:0]    mode;
   logic          frame_start;
   logic          line_start;
   logic          pix_en;
   logic [AW-1:0] rd_addr;
   logic [DW-1:0] rd_data;
   logic [7:0]    pix_index;
   logic          pix_valid;
   logic          underrun;

   logic [DW-1:0] mem [NWORDS];
   logic [AW-1:0] prev_addr = '0;
   int            addr_q[$];
   int            addr_max = 0;
   int            n_checks = 0;
   int            n_fail   = 0;

   frame_scanner #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .mode        (mode),
      .frame_start (frame_start),
      .line_start  (line_start),
      .pix_en      (pix_en),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .pix_index   (pix_index),
      .pix_valid   (pix_valid),
      .underrun    (underrun)
   );

   always #5 clk = ~clk;

   // Synchronous-read frame buffer; also logs every new address presented.
   always @(posedge clk) begin
      rd_data <= (int'(rd_addr) < NWORDS) ? mem[rd_addr] : '0;
      if (!reset) begin
         if (int'(rd_addr) > addr_max) addr_max = int'(rd_addr);
         if (rd_addr != prev_addr) addr_q.push_back(int'(rd_addr));
      end
      prev_addr = rd_addr;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Expected palette index of display pixel x on the given display line.
   function automatic logic [7:0] exp_pix(input int md, input int line, input int x);
      int            row, wpr, ppw, bpp, sp, lsb;
      logic [DW-1:0] w;
      row = (md == 0 || md == 2) ? line / 2 : line;
      wpr = (md == 0 || md == 2) ? 32 : 16;
      ppw = (md == 1 || md == 3) ? 40 : 20;
      bpp = (md == 0) ? 8 : (md == 3) ? 2 : 4;
      sp  = (md <= 1) ? (x % ppw) / 2 : x % ppw;
      lsb = DW - bpp * (sp + 1);
      w   = mem[row * wpr + x / ppw] >> lsb;
      return w[7:0] & 8'((1 << bpp) - 1);
   endfunction

   task automatic run_line(input int md, input int line, input bit with_frame, input bit dense,
                           input int npix);
      int base, wpr, prev_before, lo;
      wpr = (md == 0 || md == 2) ? 32 : 16;
      base = ((md == 0 || md == 2) ? line / 2 : line) * wpr;
      repeat (4) step();
      prev_before = int'(prev_addr);
      addr_q.delete();
      frame_start = with_frame;
      mode        = 2'(md);
      line_start  = 1'b1;
      step();
      frame_start = 1'b0;
      line_start  = 1'b0;
      repeat (3) step();
      for (int x = 0; x < npix; x++) begin
         if (!dense) repeat ($urandom_range(0, 2)) step();
         pix_en = 1'b1;
         step();
         pix_en = 1'b0;
         check("pix_valid", 32'(pix_valid), 1);
         check($sformatf("pix m%0d l%0d x%0d", md, line, x), 32'(pix_index),
               32'(exp_pix(md, line, x)));
      end
      if (npix == 640) begin
         lo = base + ((prev_before == base) ? 1 : 0);
         check($sformatf("addr_count m%0d l%0d", md, line), addr_q.size(), base + wpr - lo);
         if (addr_q.size() > 0) begin
            check($sformatf("addr_first m%0d l%0d", md, line), addr_q[0], lo);
            check($sformatf("addr_last m%0d l%0d", md, line), addr_q[$], base + wpr - 1);
         end
         check($sformatf("underrun m%0d l%0d", md, line), 32'(underrun), 0);
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int md;
      reset = 1'b1; mode = 2'd0; frame_start = 1'b0; line_start = 1'b0; pix_en = 1'b0;
      for (int i = 0; i < NWORDS; i++) mem[i] = {$urandom, $urandom, 16'($urandom)};
      repeat (3) step();
      check("rst_rd_addr", 32'(rd_addr), 0);
      check("rst_pix_index", 32'(pix_index), 0);
      check("rst_pix_valid", 32'(pix_valid), 0);
      check("rst_underrun", 32'(underrun), 0);
      reset = 1'b0;
      step();

      // pix_en before any line has been fetched
      pix_en = 1'b1;
      step();
      pix_en = 1'b0;
      check("early_pix_valid", 32'(pix_valid), 1);
      check("early_pix_index", 32'(pix_index), 0);
      check("early_underrun", 32'(underrun), 1);
      step();
      check("idle_pix_valid", 32'(pix_valid), 0);
      check("underrun_sticky", 32'(underrun), 1);
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      check("underrun_cleared", 32'(underrun), 0);

      // 640x480x2: 16 words per line
      run_line(3, 0, 1'b1, 1'b0, 640);
      run_line(3, 1, 1'b0, 1'b1, 640);

      // 320x240x8: lines 0 and 1 share row 0, line 2 starts at 32
      run_line(0, 0, 1'b1, 1'b0, 640);
      run_line(0, 1, 1'b0, 1'b1, 640);
      run_line(0, 2, 1'b0, 1'b0, 640);

      // 320x480x4 with back-to-back pix_en, then a line abandoned mid-way
      run_line(1, 0, 1'b1, 1'b1, 640);
      run_line(1, 1, 1'b0, 1'b0, 100);
      run_line(1, 2, 1'b0, 1'b1, 640);

      // Reset in the middle of a mode 0 line
      run_line(0, 0, 1'b1, 1'b1, 45);
      reset = 1'b1;
      step();
      check("midrst_rd_addr", 32'(rd_addr), 0);
      check("midrst_pix_index", 32'(pix_index), 0);
      check("midrst_pix_valid", 32'(pix_valid), 0);
      check("midrst_underrun", 32'(underrun), 0);
      reset = 1'b0;
      run_line(0, 0, 1'b0, 1'b0, 640);
      md = $urandom_range(0, 3);
      run_line(md, 0, 1'b1, 1'b0, 640);
      run_line(md, 1, 1'b0, 1'b1, 640);

      // 640x240x4 to the bottom of the raster
      run_line(2, 0, 1'b1, 1'b0, 10);
      for (int l = 1; l < 479; l++) begin
         line_start = 1'b1;
         step();
         line_start = 1'b0;
         step();
         step();
      end
      run_line(2, 479, 1'b0, 1'b0, 640);
      line_start = 1'b1;
      step();
      line_start = 1'b0;
      repeat (5) step();
      check("past_last_rd_addr", 32'(rd_addr), 7679);
      pix_en = 1'b1;
      step();
      pix_en = 1'b0;
      check("past_last_pix_index", 32'(pix_index), 0);
      check("past_last_underrun", 32'(underrun), 1);
      check("addr_max", addr_max, 7679);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/frame_scanner.md
FRAME_SCANNER -- requirements
Module: frame_scanner

Interface
REQ-001 Parameter DATA_WIDTH, default 80: width of one frame buffer word, 10 bytes.
REQ-002 Parameter ADDR_WIDTH, default 13: frame buffer word address width, covering 7680 words.
REQ-003 clk  in  1  sole clock; the frame buffer read port also runs on clk.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 mode  in  2  0=320x240x8bpp, 1=320x480x4bpp, 2=640x240x4bpp, 3=640x480x2bpp; sampled only on frame_start.
REQ-006 frame_start  in  1  one-cycle pulse: new frame, line counter and underrun cleared.
REQ-007 line_start  in  1  one-cycle pulse: begin fetch for next display line, at least 4 clk before its first pix_en.
REQ-008 pix_en  in  1  consume one display pixel; at most 640 per line, at most one per clk.
REQ-009 rd_addr  out  ADDR_WIDTH  frame buffer read address; the write-enable on that port is tied 0.
REQ-010 rd_data  in  DATA_WIDTH  frame buffer read data, valid the clk after rd_addr is presented.
REQ-011 pix_index  out  8  palette index, zero-extended for 4bpp/2bpp.
REQ-012 pix_valid  out  1  pix_index valid; registered, asserted the clk after a serviced pix_en.
REQ-013 underrun  out  1  sticky: pix_en arrived with no buffered pixel.

Function
REQ-014 Display raster is always 640x480; modes 0/1 double each pixel horizontally; modes 0/2 show each stored row on two consecutive display lines.
REQ-015 Words per stored row: 32 (modes 0,2), 16 (modes 1,3); row base = row x words-per-row, where row = line>>1 (modes 0,2) or line (modes 1,3).
REQ-016 Display pixels per word: 20 (modes 0,2), 40 (modes 1,3); first pixel in most-significant bits (bit 79 down).
REQ-017 The block holds a 2-entry word buffer; the fetcher issues a read whenever an entry is free, counting in-flight reads, and stops after the last word of the row.
REQ-018 Fetch FSM states: IDLE, FETCH, DRAIN; line_start -> FETCH with buffer flushed and address = row base; last word issued -> DRAIN; buffer empty in DRAIN -> IDLE.
REQ-019 line_start mid-line abandons the current line: buffer flushed, in-flight data discarded, fetch restarts at the new row base.
REQ-020 Line counter 0..479 increments on each line_start after the first of a frame; line_start beyond line 479 is ignored (FSM stays IDLE).
REQ-021 frame_start and line_start in the same clk: frame_start is applied first, then line 0 fetch begins.
REQ-022 pix_en with empty buffer: pix_index=0, pix_valid=1, underrun set until next frame_start or reset.
REQ-023 Simultaneous buffer pop and word arrival in one clk shall not drop or duplicate a word.
REQ-024 rd_addr arithmetic is unsigned, ADDR_WIDTH bits; no address exceeds 7679.

Reset
REQ-025 On reset: FSM IDLE, buffer empty, in-flight count 0, line counter 0, latched mode 0, rd_addr 0, pix_index 0, pix_valid 0, underrun 0.
REQ-026 Reset mid-line discards in-flight read data arriving the clk after reset.

Structure
REQ-027 Package ogege_video_pkg holds the mode encoding, 640/480 raster constants, words-per-row and pixels-per-word tables.
REQ-028 Sub-module scan_word_fifo: 2-entry DATA_WIDTH FIFO with flush, push, pop, count.

Verification
REQ-029 Mode 3, frame_start+line_start, 640 pix_en: reads at addresses 0..15; pixel 0 = rd_data[79:78] of word 0.
REQ-030 Mode 0, display lines 0 and 1: both fetch words 0..31; each byte output twice; line 2 starts at address 32.
REQ-031 Mode 2, line 479: row 239, reads 7648..7679; next line_start ignored, rd_addr stays put.
REQ-032 Mode 1, pix_en every clk from 4 clk after line_start: no underrun over the full line.
REQ-033 pix_en before any line_start: pix_index 0, underrun 1; next frame_start clears it.
REQ-034 Reset asserted mid-line in mode 0: next clk all outputs at reset values; subsequent frame renders correctly.
